demultiplexor_1in_3out: RTL and testbench
=========================================

// Module: demultiplexor_1in_3out
// PURPOSE
// - Inverse of the 3-to-1 datapath multiplexer: one DATA_W input stream is steered to one of three output channels A/B/C by a 2-bit Sel.
// - Each channel has a one-entry registered output slot with valid/ready, so the three consumers stall independently.
// - Sits between the datapath result bus and its three destinations.
// - Per-channel delivered-word counters for debug/verification.
// PARAMETERS
// - DATA_W  16  width of DatoIn and SalidaA/B/C
// - CNT_W   8   width of each delivered-word counter
// PORTS
// - clk      in   1       single clock, all state on rising edge
// - reset    in   1       synchronous, active-high
// - DatoIn   in   DATA_W  input word
// - Sel      in   2       destination: 0=A, 1=B, 2=C, 3=invalid
// - InValid  in   1       DatoIn/Sel valid this cycle
// - InReady  out  1       block accepts DatoIn/Sel this cycle
// - SalidaA  out  DATA_W  channel A data (likewise SalidaB, SalidaC)
// - ValidA   out  1       channel A holds a word (likewise ValidB, ValidC)
// - ReadyA   in   1       channel A consumer takes the word (likewise ReadyB, ReadyC)
// - SelError out  1       one-cycle pulse: a word with Sel==3 was discarded
// - CountA   out  CNT_W   words delivered on A (likewise CountB, CountC)
// BEHAVIOUR
// - Reset: ValidA/B/C=0, SalidaA/B/C=0, CountA/B/C=0, SelError=0. InReady forced 0 while reset=1.
// - Reset mid-operation: held words are dropped, no handshake completes. Counters do not advance.
// - Accept: InValid && InReady at a rising edge.
// - InReady (combinational): Sel==3 -> 1; else !Valid[Sel] || Ready[Sel]. This is a ready-to-ready path, with no head-of-line blocking.
// - Latency: a word accepted at edge N appears on Salida[Sel] with Valid[Sel]=1 after edge N (visible in cycle N+1).
// - Hold rule: while ValidX && !ReadyX, SalidaX and ValidX are stable.
// - Drain: ValidX && ReadyX at an edge clears ValidX, unless a new word for X is accepted at the same edge.
//   In that case SalidaX takes the new word and ValidX stays 1, so full throughput is one word/cycle/channel.
// - Only the slot addressed by Sel is written. The other slots are unaffected by the accept.
// - Sel==3 accepted: word discarded, no Valid raised, SelError=1 for exactly the next cycle. Back-to-back invalid words give SelError held high.
// - Sel and DatoIn are ignored when InValid=0.
// - CountX += 1 (mod 2^CNT_W, wraps silently) on each ValidX && ReadyX edge.
// - All outputs except InReady are registered.
// STRUCTURE
// - Shared package: CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, SEL_INVALID=2'd3; defaults DATA_W=16, CNT_W=8.
// - Sub-module demux_out_slot, instantiated three times.
//   - Ports: clk, reset, load, din, ready, dout, valid, count.
//   - Contains the one-entry register, the drain/refill rule and the wrap counter.
// - Top level holds the Sel decode, the InReady mux and the SelError register.
// TESTING
// - Reset: reset=1 for 2 cycles with InValid=1 -> InReady=0, all Valid=0, Counts=0, SelError=0. After release, InReady=1.
// - Basic route: Sel=0, DatoIn=16'hA5A5, ReadyA=1 for one cycle
//   -> next cycle SalidaA=16'hA5A5, ValidA=1, ValidB=ValidC=0. Cycle after: ValidA=0, CountA=1.
// - Backpressure: ReadyB=0, send 16'h1111 then 16'h2222 to B -> second cycle InReady=0, SalidaB holds 16'h1111.
//   - Raise ReadyB -> same edge drains 16'h1111 and accepts 16'h2222. ValidB stays 1, CountB=1.
// - Independence: B stalled full, Sel=2 DatoIn=16'h3333 -> InReady=1, ValidC=1 next cycle, SalidaB unchanged.
// - Invalid sel: Sel=3, DatoIn=16'hDEAD -> InReady=1, SelError=1 for exactly one cycle, no Valid rises, Counts unchanged.
// - Wrap/reset: CNT_W=4, stream 16 words to A with ReadyA=1 -> CountA returns to 0.
//   - Then stall A with ValidA=1 and pulse reset -> ValidA=0, CountA=0 next cycle.

Source files
------------

// File: rtl/demultiplexor_1in_3out_pkg.sv
// Shared definitions for the 1-in/3-out demultiplexer: channel codes,
// default widths and the destination decode helper.
package demultiplexor_1in_3out_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        CH_A        = 2'd0,
        CH_B        = 2'd1,
        CH_C        = 2'd2,
        SEL_INVALID = 2'd3
    } sel_e;

    // One-hot slot select; the invalid code maps to no slot at all.
    function automatic logic [2:0] sel_to_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel_e'(sel))
            CH_A:    oh = 3'b001;
            CH_B:    oh = 3'b010;
            CH_C:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demultiplexor_1in_3out_if.sv
// Bus bundle between the producer, the demultiplexer and its three consumers.
interface demultiplexor_1in_3out_if
    import demultiplexor_1in_3out_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic [DATA_W-1:0] DatoIn;
    logic [1:0]        Sel;
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] SalidaA, SalidaB, SalidaC;
    logic              ValidA, ValidB, ValidC;
    logic              ReadyA, ReadyB, ReadyC;
    logic              SelError;
    logic [CNT_W-1:0]  CountA, CountB, CountC;

    modport slave (
        input  DatoIn, Sel, InValid, ReadyA, ReadyB, ReadyC,
        output InReady, SalidaA, SalidaB, SalidaC, ValidA, ValidB, ValidC,
        output SelError, CountA, CountB, CountC
    );

    modport master (
        output DatoIn, Sel, InValid, ReadyA, ReadyB, ReadyC,
        input  InReady, SalidaA, SalidaB, SalidaC, ValidA, ValidB, ValidC,
        input  SelError, CountA, CountB, CountC
    );
endinterface

// File: rtl/demultiplexor_1in_3out_slot.sv
// One-entry registered output slot with valid/ready drain, same-edge refill
// and a wrapping delivered-word counter.
module demux_out_slot
    import demultiplexor_1in_3out_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic [CNT_W-1:0]  count
);
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              drain;

    // Next-state: a load wins over a drain so back-to-back words keep valid high.
    always_comb begin
        drain   = valid_q && ready;
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        if (load) begin
            data_d  = din;
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (drain) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Slot state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
            count_q <= {CNT_W{1'b0}};
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/demultiplexor_1in_3out.sv
// Steers one input stream to one of three independently back-pressured slots;
// invalid destinations are dropped and flagged with a one-cycle SelError.
module demultiplexor_1in_3out
    import demultiplexor_1in_3out_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    demultiplexor_1in_3out_if.slave  bus
);
    logic              in_ready;
    logic              accept;
    logic [2:0]        load_oh;
    logic              sel_error_q, sel_error_d;
    logic [DATA_W-1:0] dout_a, dout_b, dout_c;
    logic              valid_a, valid_b, valid_c;
    logic [CNT_W-1:0]  count_a, count_b, count_c;

    // Ready only looks at the addressed slot, so a stalled slot never blocks the others.
    always_comb begin
        in_ready = 1'b0;
        if (reset) begin
            in_ready = 1'b0;
        end else begin
            case (sel_e'(bus.Sel))
                CH_A:        in_ready = !valid_a || bus.ReadyA;
                CH_B:        in_ready = !valid_b || bus.ReadyB;
                CH_C:        in_ready = !valid_c || bus.ReadyC;
                SEL_INVALID: in_ready = 1'b1;
                default:     in_ready = 1'b1;
            endcase
        end
    end

    // Accept decode and discarded-word flag.
    always_comb begin
        accept      = bus.InValid && in_ready;
        load_oh     = accept ? sel_to_onehot(bus.Sel) : 3'b000;
        sel_error_d = accept && (sel_e'(bus.Sel) == SEL_INVALID);
    end

    // SelError register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_error_q <= 1'b0;
        end else begin
            sel_error_q <= sel_error_d;
        end
    end

    demux_out_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot_a (
        .clk(clk), .reset(reset), .load(load_oh[0]), .din(bus.DatoIn),
        .ready(bus.ReadyA), .dout(dout_a), .valid(valid_a), .count(count_a)
    );

    demux_out_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot_b (
        .clk(clk), .reset(reset), .load(load_oh[1]), .din(bus.DatoIn),
        .ready(bus.ReadyB), .dout(dout_b), .valid(valid_b), .count(count_b)
    );

    demux_out_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot_c (
        .clk(clk), .reset(reset), .load(load_oh[2]), .din(bus.DatoIn),
        .ready(bus.ReadyC), .dout(dout_c), .valid(valid_c), .count(count_c)
    );

    assign bus.InReady  = in_ready;
    assign bus.SalidaA  = dout_a;
    assign bus.SalidaB  = dout_b;
    assign bus.SalidaC  = dout_c;
    assign bus.ValidA   = valid_a;
    assign bus.ValidB   = valid_b;
    assign bus.ValidC   = valid_c;
    assign bus.CountA   = count_a;
    assign bus.CountB   = count_b;
    assign bus.CountC   = count_c;
    assign bus.SelError = sel_error_q;

endmodule

// File: tb/tb_demultiplexor_1in_3out.sv
// Bench for demultiplexor_1in_3out: directed vector table, wrap/reset sequence
// and a randomized run against a slot-level reference model.
module tb_demultiplexor_1in_3out;
    localparam int DW = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    demultiplexor_1in_3out_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    demultiplexor_1in_3out #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    typedef struct packed {
        logic          rst;
        logic          iv;
        logic [1:0]    sel;
        logic [DW-1:0] din;
        logic [2:0]    rdy;      // {C,B,A}
        logic          e_inrdy;  // before the edge
        logic [2:0]    e_v;      // after the edge, {C,B,A}
        logic [DW-1:0] e_a, e_b, e_c;
        logic          e_err;
        logic [CW-1:0] e_ca, e_cb, e_cc;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [1:0] sel,
                         input logic [DW-1:0] din, input logic [2:0] rdy);
        reset       = rst;
        bus.InValid = iv;
        bus.Sel     = sel;
        bus.DatoIn  = din;
        bus.ReadyA  = rdy[0];
        bus.ReadyB  = rdy[1];
        bus.ReadyC  = rdy[2];
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] ev,
                              input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                              input logic [DW-1:0] ec, input logic eerr,
                              input logic [CW-1:0] eca, input logic [CW-1:0] ecb,
                              input logic [CW-1:0] ecc);
        chk({tag, "_valid"}, {29'd0, bus.ValidC, bus.ValidB, bus.ValidA}, {29'd0, ev});
        chk({tag, "_salidaA"}, {16'd0, bus.SalidaA}, {16'd0, ea});
        chk({tag, "_salidaB"}, {16'd0, bus.SalidaB}, {16'd0, eb});
        chk({tag, "_salidaC"}, {16'd0, bus.SalidaC}, {16'd0, ec});
        chk({tag, "_selerr"}, {31'd0, bus.SelError}, {31'd0, eerr});
        chk({tag, "_countA"}, {28'd0, bus.CountA}, {28'd0, eca});
        chk({tag, "_countB"}, {28'd0, bus.CountB}, {28'd0, ecb});
        chk({tag, "_countC"}, {28'd0, bus.CountC}, {28'd0, ecc});
    endtask

    // Reference model state: one slot per channel.
    logic [DW-1:0] m_data [3];
    logic          m_full [3];
    logic [CW-1:0] m_cnt  [3];
    logic          m_err;

    initial begin
        //        rst   iv    sel   din       rdy     inrdy v       A         B         C         err   cA    cB    cC
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 16'h1234, 3'b000, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 2'd0, 16'h1234, 3'b000, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 3'b000, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0};
        tbl[3]  = '{1'b0, 1'b1, 2'd0, 16'hA5A5, 3'b001, 1'b1, 3'b001, 16'hA5A5, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 3'b001, 1'b1, 3'b000, 16'hA5A5, 16'h0000, 16'h0000, 1'b0, 4'd1, 4'd0, 4'd0};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, 16'h1111, 3'b000, 1'b1, 3'b010, 16'hA5A5, 16'h1111, 16'h0000, 1'b0, 4'd1, 4'd0, 4'd0};
        tbl[6]  = '{1'b0, 1'b1, 2'd1, 16'h2222, 3'b000, 1'b0, 3'b010, 16'hA5A5, 16'h1111, 16'h0000, 1'b0, 4'd1, 4'd0, 4'd0};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 16'h2222, 3'b010, 1'b1, 3'b010, 16'hA5A5, 16'h2222, 16'h0000, 1'b0, 4'd1, 4'd1, 4'd0};
        tbl[8]  = '{1'b0, 1'b1, 2'd2, 16'h3333, 3'b000, 1'b1, 3'b110, 16'hA5A5, 16'h2222, 16'h3333, 1'b0, 4'd1, 4'd1, 4'd0};
        tbl[9]  = '{1'b0, 1'b1, 2'd3, 16'hDEAD, 3'b000, 1'b1, 3'b110, 16'hA5A5, 16'h2222, 16'h3333, 1'b1, 4'd1, 4'd1, 4'd0};
        tbl[10] = '{1'b0, 1'b0, 2'd3, 16'h0000, 3'b000, 1'b1, 3'b110, 16'hA5A5, 16'h2222, 16'h3333, 1'b0, 4'd1, 4'd1, 4'd0};
        tbl[11] = '{1'b0, 1'b1, 2'd3, 16'hBEEF, 3'b000, 1'b1, 3'b110, 16'hA5A5, 16'h2222, 16'h3333, 1'b1, 4'd1, 4'd1, 4'd0};
        tbl[12] = '{1'b0, 1'b1, 2'd3, 16'hBEEF, 3'b000, 1'b1, 3'b110, 16'hA5A5, 16'h2222, 16'h3333, 1'b1, 4'd1, 4'd1, 4'd0};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 16'h0000, 3'b000, 1'b1, 3'b110, 16'hA5A5, 16'h2222, 16'h3333, 1'b0, 4'd1, 4'd1, 4'd0};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 16'h0000, 3'b110, 1'b1, 3'b000, 16'hA5A5, 16'h2222, 16'h3333, 1'b0, 4'd1, 4'd2, 4'd1};
        tbl[15] = '{1'b0, 1'b0, 2'd1, 16'h5555, 3'b000, 1'b1, 3'b000, 16'hA5A5, 16'h2222, 16'h3333, 1'b0, 4'd1, 4'd2, 4'd1};

        drive(1'b1, 1'b0, 2'd0, 16'h0000, 3'b000);
        #1;

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].sel, tbl[i].din, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d_inready", i), {31'd0, bus.InReady}, {31'd0, tbl[i].e_inrdy});
            edge_step();
            check_outs($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_a, tbl[i].e_b, tbl[i].e_c,
                       tbl[i].e_err, tbl[i].e_ca, tbl[i].e_cb, tbl[i].e_cc);
        end

        // Counter wrap on A, then reset while A is stalled full.
        drive(1'b1, 1'b0, 2'd0, 16'h0000, 3'b000);
        edge_step();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 2'd0, 16'(i + 100), 3'b001);
            edge_step();
        end
        check_outs("wrap_15", 3'b001, 16'd115, 16'h0000, 16'h0000, 1'b0, 4'd15, 4'd0, 4'd0);
        drive(1'b0, 1'b1, 2'd0, 16'h7777, 3'b001);
        edge_step();
        check_outs("wrap_0", 3'b001, 16'h7777, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0);
        drive(1'b0, 1'b1, 2'd0, 16'h8888, 3'b001);
        edge_step();
        check_outs("wrap_1", 3'b001, 16'h8888, 16'h0000, 16'h0000, 1'b0, 4'd1, 4'd0, 4'd0);
        drive(1'b0, 1'b1, 2'd0, 16'h9999, 3'b000);
        #1;
        chk("stall_inready", {31'd0, bus.InReady}, 32'd0);
        edge_step();
        check_outs("stall_hold", 3'b001, 16'h8888, 16'h0000, 16'h0000, 1'b0, 4'd1, 4'd0, 4'd0);
        drive(1'b1, 1'b1, 2'd0, 16'h4444, 3'b111);
        #1;
        chk("rst_inready", {31'd0, bus.InReady}, 32'd0);
        edge_step();
        check_outs("stall_reset", 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0);

        // Randomized run against the slot model.
        for (int c = 0; c < 3; c++) begin
            m_data[c] = '0;
            m_full[c] = 1'b0;
            m_cnt[c]  = '0;
        end
        m_err = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic          r_rst, r_iv, exp_rdy, acc;
            logic [1:0]    r_sel;
            logic [DW-1:0] r_din;
            logic [2:0]    r_rdy;
            r_rst = ($urandom_range(0, 49) == 0);
            r_iv  = 1'($urandom_range(0, 3) != 0);
            r_sel = 2'($urandom_range(0, 3));
            r_din = 16'($urandom);
            r_rdy = 3'($urandom);
            drive(r_rst, r_iv, r_sel, r_din, r_rdy);
            #1;
            if (r_rst) exp_rdy = 1'b0;
            else if (r_sel == 2'd3) exp_rdy = 1'b1;
            else exp_rdy = !m_full[r_sel] || r_rdy[r_sel];
            chk($sformatf("rnd%0d_inready", cyc), {31'd0, bus.InReady}, {31'd0, exp_rdy});
            acc = r_iv && exp_rdy;
            if (r_rst) begin
                for (int c = 0; c < 3; c++) begin
                    m_data[c] = '0;
                    m_full[c] = 1'b0;
                    m_cnt[c]  = '0;
                end
                m_err = 1'b0;
            end else begin
                for (int c = 0; c < 3; c++) begin
                    if (m_full[c] && r_rdy[c]) begin
                        m_cnt[c]  = m_cnt[c] + 4'd1;
                        m_full[c] = 1'b0;
                    end
                end
                if (acc && r_sel != 2'd3) begin
                    m_data[r_sel] = r_din;
                    m_full[r_sel] = 1'b1;
                end
                m_err = acc && (r_sel == 2'd3);
            end
            edge_step();
            check_outs($sformatf("rnd%0d", cyc), {m_full[2], m_full[1], m_full[0]},
                       m_data[0], m_data[1], m_data[2], m_err, m_cnt[0], m_cnt[1], m_cnt[2]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
